instr_inv_source: RTL and testbench

- Producer end of the instruction-invalidation protocol; drives inv_valid/inv_addr and consumes per-sink inv_completed.
- Accepts line-granular invalidation requests from the store/snoop path and buffers them in a FIFO.
- Expands each request into word addresses and presents them one at a time, advancing only when every consumer has completed.
- Consumers are the branch predictor, the icache and similar blocks; idle lets fence.i logic wait for drain.

---
 rtl/cva5_types.sv | 13 +
 rtl/inv_addr_fifo.sv | 59 +++++
 rtl/instr_inv_source.sv | 111 +++++++++++
 tb/tb_instr_inv_source.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cva5_types.sv
// Shared types for the instruction-invalidation source: FSM states and word-address type.
package cva5_types;

    localparam int INV_ADDR_W = 30;

    typedef logic [INV_ADDR_W-1:0] inv_word_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } inv_state_t;

endpackage

// File: rtl/inv_addr_fifo.sv
// Request FIFO for line invalidations; exposes head, status and a per-entry view for coalescing.
module inv_addr_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 30
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [ADDR_W-1:0]            i_data,
    output logic [ADDR_W-1:0]            o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_one,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_lines,
    output logic [DEPTH-1:0]             o_tail_vld
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] r_mem;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [PTR_W:0]               r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_one   = (r_count == (PTR_W+1)'(1));
    assign o_lines = r_mem;

    // An entry is a coalesce candidate when occupied and not the head (offset 0 from rd_ptr).
    for (genvar g = 0; g < DEPTH; g++) begin : g_tail
        logic [PTR_W-1:0] w_off;
        assign w_off         = PTR_W'(g) - r_rd_ptr;
        assign o_tail_vld[g] = (w_off != '0) && ({1'b0, w_off} < r_count);
    end

endmodule

// File: rtl/instr_inv_source.sv
// Producer end of the instruction-invalidation protocol: queues line requests, issues word
// invalidations and waits for all sinks. Optional duplicate dropping via INSTR_INV_COALESCE_EN.
module instr_inv_source
    import cva5_types::*;
#(
    parameter int DEPTH      = 4,
    parameter int NUM_SINKS  = 2,
    parameter int LINE_WORDS = 1,
    parameter int ADDR_W     = INV_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 req_ready,
    output logic                 inv_valid,
    output logic [ADDR_W-1:0]    inv_addr,
    input  logic [NUM_SINKS-1:0] inv_completed,
    output logic                 idle
);
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

    inv_state_t                   r_state;
    inv_state_t                   w_next_state;
    logic [CNT_W-1:0]             r_word_cnt;
    logic [NUM_SINKS-1:0]         r_done;

    logic [ADDR_W-1:0]            w_head;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_one;
    logic [DEPTH-1:0][ADDR_W-1:0] w_lines;
    logic [DEPTH-1:0]             w_tail_vld;
    logic [ADDR_W-1:0]            w_line_addr;
    logic                         w_push;
    logic                         w_dup;
    logic                         w_store;
    logic                         w_word_done;
    logic                         w_last;
    logic                         w_pop;

    assign w_line_addr = req_addr & LINE_MASK;
    assign w_push      = req_valid & ~w_full;

`ifdef INSTR_INV_COALESCE_EN
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_tail_vld[i] && (w_lines[i] == w_line_addr)) w_dup = 1'b1;
        end
    end
`else
    logic [DEPTH*(ADDR_W+1)-1:0] w_unused_coal;
    assign w_unused_coal = {w_lines, w_tail_vld};
    assign w_dup         = 1'b0;
`endif

    assign w_store     = w_push & ~w_dup;
    assign w_word_done = (r_state == ISSUE) && (&(r_done | inv_completed));
    assign w_last      = (r_word_cnt == CNT_W'(LINE_WORDS - 1));
    assign w_pop       = w_word_done & w_last;

    inv_addr_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_store),
        .i_pop      (w_pop),
        .i_data     (w_line_addr),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_one      (w_one),
        .o_lines    (w_lines),
        .o_tail_vld (w_tail_vld)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_store) w_next_state = ISSUE;
            ISSUE:   if (w_pop && w_one && !w_store) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_done     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_word_done) begin
                r_word_cnt <= w_last ? '0 : r_word_cnt + 1'b1;
                r_done     <= '0;
            end else if (r_state == ISSUE) begin
                r_done <= r_done | inv_completed;
            end
        end
    end

    assign inv_valid = (r_state == ISSUE);
    assign inv_addr  = inv_valid ? (w_head | ADDR_W'(r_word_cnt)) : '0;
    assign req_ready = ~w_full;
    assign idle      = w_empty & ~inv_valid;

endmodule

// File: tb/tb_instr_inv_source.sv
// Directed self-checking bench for instr_inv_source (LINE_WORDS=1 and LINE_WORDS=4 instances).
module tb_instr_inv_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_inv_valid, a_idle;
    logic [29:0] a_req_addr, a_inv_addr;
    logic [1:0]  a_comp;
    logic        b_req_valid, b_req_ready, b_inv_valid, b_idle;
    logic [29:0] b_req_addr, b_inv_addr;
    logic [1:0]  b_comp;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_inv_source #(.DEPTH(4), .NUM_SINKS(2), .LINE_WORDS(1), .ADDR_W(30)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_addr(a_req_addr),
        .req_ready(a_req_ready), .inv_valid(a_inv_valid), .inv_addr(a_inv_addr),
        .inv_completed(a_comp), .idle(a_idle)
    );

    instr_inv_source #(.DEPTH(4), .NUM_SINKS(2), .LINE_WORDS(4), .ADDR_W(30)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .req_ready(b_req_ready), .inv_valid(b_inv_valid), .inv_addr(b_inv_addr),
        .inv_completed(b_comp), .idle(b_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [29:0] addr);
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        step();
        a_req_valid = 1'b0;
    endtask

`ifdef INSTR_INV_COALESCE_EN
    localparam int NEXP = 2;
    logic [29:0] exp_seq [3] = '{30'h80, 30'h40, 30'h0};
`else
    localparam int NEXP = 3;
    logic [29:0] exp_seq [3] = '{30'h80, 30'h80, 30'h40};
`endif

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_addr = '0; a_comp = '0;
        b_req_valid = 1'b0; b_req_addr = '0; b_comp = '0;
        #3;
        chk("rst_valid", 32'(a_inv_valid), 32'd0);
        chk("rst_ready", 32'(a_req_ready), 32'd1);
        chk("rst_idle",  32'(a_idle),      32'd1);
        chk("rst_addr",  32'(a_inv_addr),  32'd0);
        step();
        rst_n = 1'b1;
        step();

        // single request, sinks complete at different cycles
        push_a(30'h100);
        chk("t1_valid", 32'(a_inv_valid), 32'd1);
        chk("t1_addr",  32'(a_inv_addr),  32'h100);
        chk("t1_busy",  32'(a_idle),      32'd0);
        step();
        a_comp = 2'b01; step(); a_comp = 2'b00;
        chk("t1_hold_s0", 32'(a_inv_valid), 32'd1);
        step(); step();
        chk("t1_addr_stable", 32'(a_inv_addr), 32'h100);
        a_comp = 2'b10; step(); a_comp = 2'b00;
        chk("t1_drop", 32'(a_inv_valid), 32'd0);
        chk("t1_idle", 32'(a_idle),      32'd1);

        // stray completions while idle and repeated completion from same sink
        a_comp = 2'b11; step(); a_comp = 2'b00;
        chk("stray_idle_valid", 32'(a_inv_valid), 32'd0);
        chk("stray_idle_idle",  32'(a_idle),      32'd1);
        push_a(30'h55);
        chk("t2_addr", 32'(a_inv_addr), 32'h55);
        a_comp = 2'b01; step();
        chk("t2_s0_only", 32'(a_inv_valid), 32'd1);
        step(); a_comp = 2'b00;
        chk("t2_s0_twice", 32'(a_inv_valid), 32'd1);
        a_comp = 2'b10; step(); a_comp = 2'b00;
        chk("t2_done", 32'(a_inv_valid), 32'd0);

        // fill FIFO with sinks stalled, then pop and wrap
        for (int i = 0; i < 4; i++) push_a(30'h10 + 30'(i));
        chk("full_ready", 32'(a_req_ready), 32'd0);
        chk("full_head",  32'(a_inv_addr),  32'h10);
        a_req_valid = 1'b1; a_req_addr = 30'h14;
        step();
        chk("full_no_fifth", 32'(a_req_ready), 32'd0);
        a_comp = 2'b11; step(); a_comp = 2'b00;
        chk("pop_ready",  32'(a_req_ready), 32'd1);
        chk("pop_nogap",  32'(a_inv_valid), 32'd1);
        chk("pop_addr",   32'(a_inv_addr),  32'h11);
        step(); a_req_valid = 1'b0;
        chk("wrap_full", 32'(a_req_ready), 32'd0);
        a_comp = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wrap_order", 32'(a_inv_addr), 32'h12 + 32'(k));
            chk("wrap_nogap", 32'(a_inv_valid), 32'd1);
        end
        step(); a_comp = 2'b00;
        chk("wrap_drained", 32'(a_inv_valid), 32'd0);
        chk("wrap_idle",    32'(a_idle),      32'd1);

        // line expansion, LINE_WORDS=4
        b_req_valid = 1'b1; b_req_addr = 30'h203;
        step(); b_req_valid = 1'b0;
        chk("line_w0", 32'(b_inv_addr), 32'h200);
        b_comp = 2'b11;
        for (int k = 1; k < 4; k++) begin
            step();
            chk("line_wn", 32'(b_inv_addr), 32'h200 + 32'(k));
        end
        step(); b_comp = 2'b00;
        chk("line_end_valid", 32'(b_inv_valid), 32'd0);
        chk("line_end_idle",  32'(b_idle),      32'd1);

        // async reset mid-ISSUE with three queued
        push_a(30'h30); push_a(30'h31); push_a(30'h32);
        a_comp = 2'b01; step(); a_comp = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a_inv_valid), 32'd0);
        chk("arst_ready", 32'(a_req_ready), 32'd1);
        chk("arst_idle",  32'(a_idle),      32'd1);
        step();
        rst_n = 1'b1;
        step();
        push_a(30'h77);
        chk("arst_new_addr", 32'(a_inv_addr), 32'h77);
        a_comp = 2'b10; step(); a_comp = 2'b00;
        chk("arst_no_residual", 32'(a_inv_valid), 32'd1);
        a_comp = 2'b01; step(); a_comp = 2'b00;
        chk("arst_new_done", 32'(a_inv_valid), 32'd0);

        // duplicate handling: head 0x40, queued 0x80, then push 0x80 and 0x40
        push_a(30'h40); push_a(30'h80); push_a(30'h80); push_a(30'h40);
        chk("coal_head", 32'(a_inv_addr), 32'h40);
        a_comp = 2'b11;
        for (int k = 0; k < NEXP; k++) begin
            step();
            chk("coal_seq", 32'(a_inv_addr), 32'(exp_seq[k]));
        end
        step(); a_comp = 2'b00;
        chk("coal_drained", 32'(a_inv_valid), 32'd0);
        chk("coal_idle",    32'(a_idle),      32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
